// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the hazard sequencer's pipeline-side signals.
//   master : pipeline side (drives hazard sources, consumes controls)
//   slave  : hazard_ctrl side
// Signals:
//   ifid_rs_i/ifid_rt_i  - source regs of the instruction in IF/ID
//   idex_memread_i       - ID/EX holds a load
//   idex_rt_i            - load destination reg in ID/EX
//   branch_taken_i       - branch resolved taken in ID
//   dmem_req_i           - MEM stage data access
//   dmem_ready_i         - data memory done this cycle
//   pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o, exmem_hold_o
//                        - pipeline register controls
//   err_o                - sticky memory-timeout flag
//   stall_cnt_o          - stall cycle counter (HAZARD_PERF_CNT_EN only)
interface hazard_ctrl_if;
  logic [4:0]  ifid_rs_i;
  logic [4:0]  ifid_rt_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic        branch_taken_i;
  logic        dmem_req_i;
  logic        dmem_ready_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        if_flush_o;
  logic        idex_bubble_o;
  logic        exmem_hold_o;
  logic        err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  modport master (
    output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o,
           exmem_hold_o, err_o
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt_o
`endif
  );

  modport slave (
    input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o,
           exmem_hold_o, err_o
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt_o
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall sequencer for the 5-stage CPU.
// Resolves memory waits, taken-branch flushes and load-use hazards with
// fixed priority memstall > flush > loaduse. Outputs are Mealy.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous reset, active high (forces a pipeline clear)
//   hz    - hazard_ctrl_if.slave, pipeline hazard sources and controls
// Parameters:
//   FLUSH_CYCLES - if_flush_o cycles per taken branch (1..3)
//   MEM_TIMEOUT  - max MEM_WAIT cycles before forced release (2..255)
// Optional build macro HAZARD_PERF_CNT_EN: adds a saturating 32-bit count
// of stall cycles (pc_write_o low, not in reset) on hz.stall_cnt_o.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       memstall, loaduse;

  assign memstall = hz.dmem_req_i & ~hz.dmem_ready_i;
  assign loaduse  = hz.idex_memread_i & (hz.idex_rt_i != 5'd0) &
                    ((hz.idex_rt_i == hz.ifid_rs_i) | (hz.idex_rt_i == hz.ifid_rt_i));

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    wcnt_d           = wcnt_q;
    err_d            = err_q;
    hz.pc_write_o    = 1'b1;
    hz.ifid_write_o  = 1'b1;
    hz.if_flush_o    = 1'b0;
    hz.idex_bubble_o = 1'b0;
    hz.exmem_hold_o  = 1'b0;

    case (state_q)
      RUN, FLUSH: begin
        if (memstall) begin
          // Freeze; fcnt is kept so an interrupted flush resumes later.
          hz.pc_write_o   = 1'b0;
          hz.ifid_write_o = 1'b0;
          hz.exmem_hold_o = 1'b1;
          state_d         = MEM_WAIT;
          wcnt_d          = 8'd1;
        end else if (state_q == FLUSH) begin
          // branch_taken_i and loaduse are both masked while flushing.
          hz.if_flush_o = 1'b1;
          if (fcnt_q <= 2'd1) begin
            fcnt_d  = 2'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end else if (hz.branch_taken_i) begin
          // PC keeps loading so the branch target is fetched.
          hz.if_flush_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_RELOAD;
          end
        end else if (loaduse) begin
          hz.pc_write_o    = 1'b0;
          hz.ifid_write_o  = 1'b0;
          hz.idex_bubble_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready_i || (wcnt_q == WAIT_MAX)) begin
          // Release (normal completion or forced on timeout).
          wcnt_d  = 8'd0;
          state_d = (fcnt_q != 2'd0) ? FLUSH : RUN;
          if (!hz.dmem_ready_i) err_d = 1'b1;
        end else begin
          hz.pc_write_o   = 1'b0;
          hz.ifid_write_o = 1'b0;
          hz.exmem_hold_o = 1'b1;
          wcnt_d          = wcnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset clears the pipeline regardless of any hazard in progress.
    if (rst_i) begin
      hz.pc_write_o    = 1'b0;
      hz.ifid_write_o  = 1'b0;
      hz.if_flush_o    = 1'b1;
      hz.idex_bubble_o = 1'b1;
      hz.exmem_hold_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign hz.err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_q <= 32'd0;
    else if (!hz.pc_write_o && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
// Stimulus pushes the expected output vector per cycle into a queue; a
// monitor pops and compares at the falling edge.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // expected vector: {pc_write, ifid_write, if_flush, idex_bubble, exmem_hold, err}
  typedef struct {
    logic [5:0] v;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  hazard_ctrl_if hif();

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hif)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] irt,
                      input logic br, input logic req, input logic rdy,
                      input logic [5:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst                = r;
    hif.ifid_rs_i      = rs;
    hif.ifid_rt_i      = rt;
    hif.idex_memread_i = mr;
    hif.idex_rt_i      = irt;
    hif.branch_taken_i = br;
    hif.dmem_req_i     = req;
    hif.dmem_ready_i   = rdy;
    x.v = e;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      logic [5:0] act;
      x   = exp_q.pop_front();
      act = {hif.pc_write_o, hif.ifid_write_o, hif.if_flush_o,
             hif.idex_bubble_o, hif.exmem_hold_o, hif.err_o};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
    end
  end

  localparam logic [5:0] RST  = 6'b001100;
  localparam logic [5:0] DEF  = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] FL   = 6'b111000;
  localparam logic [5:0] HOLD = 6'b000010;

  initial begin
    hif.ifid_rs_i = '0; hif.ifid_rt_i = '0; hif.idex_memread_i = 0;
    hif.idex_rt_i = '0; hif.branch_taken_i = 0; hif.dmem_req_i = 0;
    hif.dmem_ready_i = 0;
    //    name           rst rs  rt  mr irt br req rdy exp
    step("reset0",        1, 0,  0,  0, 0,  0, 0,  0, RST);
    step("reset1",        1, 0,  0,  0, 0,  0, 0,  0, RST);
    step("idle",          0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("loaduse_rs",    0, 5,  0,  1, 5,  0, 0,  0, LU);
    step("after_lu",      0, 5,  0,  0, 0,  0, 0,  0, DEF);
    step("lu_r0",         0, 0,  0,  1, 0,  0, 0,  0, DEF);
    step("loaduse_rt",    0, 3,  7,  1, 7,  0, 0,  0, LU);
    step("branch",        0, 0,  0,  0, 0,  1, 0,  0, FL);
    step("flush2",        0, 0,  0,  0, 0,  0, 0,  0, FL);
    step("flush_done",    0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("br_lu",         0, 5,  0,  1, 5,  1, 0,  0, FL);
    step("flush_lu_mask", 0, 5,  0,  1, 5,  0, 0,  0, FL);
    step("idle2",         0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("mw_hold1",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("mw_hold2",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("mw_hold3",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("mw_release",    0, 0,  0,  0, 0,  0, 1,  1, DEF);
    step("mw_after",      0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("br_then_ms",    0, 0,  0,  0, 0,  1, 0,  0, FL);
    step("ms_in_flush",   0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("ms_release",    0, 0,  0,  0, 0,  0, 1,  1, DEF);
    step("flush_resume",  0, 0,  0,  0, 0,  0, 0,  0, FL);
    step("resume_done",   0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("to_hold1",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("to_hold2",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("to_hold3",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("to_hold4",      0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("to_release",    0, 0,  0,  0, 0,  0, 1,  0, DEF);
    step("err_set",       0, 0,  0,  0, 0,  0, 0,  0, DEF | 6'b1);
    step("req_rdy_same",  0, 0,  0,  0, 0,  0, 1,  1, DEF | 6'b1);
    step("err_sticky",    0, 0,  0,  0, 0,  0, 0,  0, DEF | 6'b1);
    step("rst_err_held",  1, 0,  0,  0, 0,  0, 0,  0, RST | 6'b1);
    step("err_cleared",   0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("mw_abort_hold", 0, 0,  0,  0, 0,  0, 1,  0, HOLD);
    step("mw_abort_rst",  1, 0,  0,  0, 0,  0, 1,  0, RST);
    step("mw_abort_run",  0, 0,  0,  0, 0,  0, 0,  0, DEF);
    step("fl_abort_br",   0, 0,  0,  0, 0,  1, 0,  0, FL);
    step("fl_abort_rst",  1, 0,  0,  0, 0,  0, 0,  0, RST);
    step("fl_abort_run",  0, 0,  0,  0, 0,  0, 0,  0, DEF);
    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage CPU.
- Drives the PC write enable, the IF/ID write-enable and flush controls, the ID/EX bubble insert and the EX/MEM/WB freeze.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Applies a fixed priority between these three hazard types.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles if_flush_o is asserted per taken branch (legal 1..3)
MEM_TIMEOUT, 16, max MEM_WAIT cycles before forced release (legal 2..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
ifid_rs_i  in  5  rs field of instruction in IF/ID
ifid_rt_i  in  5  rt field of instruction in IF/ID
idex_memread_i  in  1  instruction in ID/EX is a load
idex_rt_i  in  5  load destination register in ID/EX
branch_taken_i  in  1  branch resolved taken in ID this cycle
dmem_req_i  in  1  MEM stage issuing data access
dmem_ready_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC register update enable
ifid_write_o  out  1  IF/ID write enable (1 = load, 0 = hold)
if_flush_o  out  1  IF/ID flush (zero pc4/instr)
idex_bubble_o  out  1  force ID/EX control signals to zero
exmem_hold_o  out  1  freeze EX/MEM and MEM/WB registers
err_o  out  1  sticky memory-timeout flag

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. State register, flush counter fcnt (2b), wait counter wcnt (8b) and err_o are all registered.
- Outputs are combinational from the current state and inputs (Mealy).
- Reset (rst_i=1 at clock edge) puts the block in:
  - state=RUN, fcnt=0, wcnt=0, err_o=0.
- While rst_i=1, outputs are forced regardless of state:
  - pc_write_o=0, ifid_write_o=0, if_flush_o=1, idex_bubble_o=1, exmem_hold_o=0.
  - This clears the pipeline. Reset mid-MEM_WAIT or mid-FLUSH aborts it.
- Default outputs (no hazard): pc_write_o=1, ifid_write_o=1, others 0.
- Hazard definitions:
  - memstall = dmem_req_i & ~dmem_ready_i.
  - loaduse = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- Priority in RUN and FLUSH: memstall > flush (branch_taken_i or state FLUSH) > loaduse.
- memstall:
  - Outputs: pc_write_o=0, ifid_write_o=0, exmem_hold_o=1, if_flush_o=0, idex_bubble_o=0.
  - Next state MEM_WAIT, wcnt=1. fcnt is preserved, so an interrupted FLUSH resumes afterwards.
- MEM_WAIT:
  - Outputs stay as for memstall.
  - Each cycle with dmem_ready_i=0: wcnt++.
  - dmem_ready_i=1: in this cycle exmem_hold_o=0, pc_write_o=1, ifid_write_o=1 (release). Next state is FLUSH if fcnt!=0, else RUN.
  - Timeout: wcnt==MEM_TIMEOUT with ready still 0 → release as above and set err_o=1 (sticky until reset).
- Taken branch in RUN (no memstall):
  - if_flush_o=1 and idex_bubble_o=0; pc_write_o=1 so the branch target is loaded.
  - If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1.
- FLUSH: if_flush_o=1, fcnt--; at fcnt reaching 0, next state RUN. branch_taken_i is ignored while in FLUSH.
- loaduse (RUN, no branch): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for that cycle only. A back-to-back load-use is not re-detected because the bubble clears idex_memread.
- Branch and loaduse in the same cycle: the flush wins and no bubble is inserted.
- Register $0 never causes a load-use stall.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output stall_cnt_o (32b) counting cycles with pc_write_o=0 while rst_i=0.
  - Saturates at 0xFFFFFFFF; cleared by reset.
- Undefined: the port and counter are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles → if_flush_o=1, idex_bubble_o=1, pc_write_o=0, err_o=0. Release → defaults 1,1,0,0,0.
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 → one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. With idex_rt_i=0 → no stall.
- Branch, FLUSH_CYCLES=2: branch_taken_i=1 for one cycle → if_flush_o=1 for exactly 2 cycles, pc_write_o=1 throughout.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles then 1 → exmem_hold_o=1 for 3 cycles, released on the ready cycle, err_o stays 0.
- Timeout, MEM_TIMEOUT=4: ready never asserted → forced release after 4 hold cycles, err_o=1 and sticky.
- Simultaneous events:
  - branch + loaduse in the same cycle → if_flush_o=1, idex_bubble_o=0.
  - memstall during FLUSH → freeze first, then the remaining flush cycle completes after ready.
